// File: rtl/seq_count_ctrl.sv
// Start/done sequencer with an integrated up-counter, programmable limit and multi-pass repeat.
// Define SEQ_COUNT_CTRL_MEALY_DONE_EN to drop the DONE state and raise done combinationally in the last RUN cycle.
module seq_count_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  limit,
    input  logic [PASS_W-1:0] passes,
    input  logic              abort,
    output logic              clr,
    output logic              inc,
    output logic              done,
    output logic              busy,
    output logic [WIDTH-1:0]  count,
    output logic [PASS_W-1:0] pass_idx
);

`ifdef SEQ_COUNT_CTRL_MEALY_DONE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WRAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WRAP = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t            state, state_d;
    logic [WIDTH-1:0]  limit_q;
    logic [PASS_W-1:0] passes_q;
    logic              tc;
    logic              last;

    assign tc   = (count == limit_q);
    assign last = (pass_idx == passes_q);

    always_comb begin
        state_d = S_IDLE;
        clr     = 1'b0;
        inc     = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        case (state)
            S_IDLE: begin
                clr = 1'b1;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                inc  = !tc;
                // abort outranks terminal count, so an aborted final pass never reports done
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tc && last) begin
`ifdef SEQ_COUNT_CTRL_MEALY_DONE_EN
                    done    = 1'b1;
                    state_d = S_IDLE;
`else
                    state_d = S_DONE;
`endif
                end else if (tc) begin
                    state_d = S_WRAP;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_WRAP: begin
                busy    = 1'b1;
                clr     = 1'b1;
                state_d = abort ? S_IDLE : S_RUN;
            end
`ifndef SEQ_COUNT_CTRL_MEALY_DONE_EN
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: begin
                clr     = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            pass_idx <= '0;
            limit_q  <= '0;
            passes_q <= '0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && start) begin
                limit_q  <= limit;
                passes_q <= passes;
            end
            // returning to IDLE (finish or abort) zeroes the counters so IDLE always shows 0
            if (state_d == S_IDLE || clr)
                count <= '0;
            else if (inc)
                count <= count + 1'b1;
            if (state_d == S_IDLE)
                pass_idx <= '0;
            else if (state == S_WRAP)
                pass_idx <= pass_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_count_ctrl.sv
// Directed bench for seq_count_ctrl, default (Moore done) build, WIDTH=8, PASS_W=4.
module tb_seq_count_ctrl;
    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] limit = '0;
    logic [3:0] passes = '0;
    logic       abort = 1'b0;
    logic       clr, inc, done, busy;
    logic [7:0] count;
    logic [3:0] pass_idx;

    int n_chk  = 0;
    int n_fail = 0;

    seq_count_ctrl #(.WIDTH(8), .PASS_W(4)) dut (
        .clock(clock), .rst(rst), .start(start), .limit(limit), .passes(passes),
        .abort(abort), .clr(clr), .inc(inc), .done(done), .busy(busy),
        .count(count), .pass_idx(pass_idx)
    );

    always #5 clock = ~clock;

    // single pass limit=3, start pulses in cycles 0,2,5,6
    int a_start [0:7] = '{1, 0, 1, 0, 0, 1, 1, 0};
    int a_cnt   [0:7] = '{0, 0, 1, 2, 3, 3, 0, 0};
    int a_busy  [0:7] = '{0, 1, 1, 1, 1, 1, 0, 1};
    int a_done  [0:7] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int a_inc   [0:7] = '{0, 1, 1, 1, 0, 0, 0, 1};
    int a_clr   [0:7] = '{1, 0, 0, 0, 0, 0, 1, 0};
    // two passes limit=2
    int b_cnt   [0:9] = '{0, 0, 1, 2, 2, 0, 1, 2, 2, 0};
    int b_pidx  [0:9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int b_clr   [0:9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int b_done  [0:9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int b_busy  [0:9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        cyc(); cyc();
        chk("rst_clr", clr, 1);   chk("rst_inc", inc, 0);
        chk("rst_done", done, 0); chk("rst_busy", busy, 0);
        chk("rst_count", count, 0); chk("rst_pidx", pass_idx, 0);
        rst = 1'b0;
        cyc();

        // A: single pass, ignored starts, limit change while busy, restart at cycle 6
        limit = 8'd3; passes = 4'd0;
        for (int c = 0; c < 8; c++) begin
            start = a_start[c][0];
            if (c == 2) limit = 8'd7;
            chk($sformatf("A_cnt_c%0d", c), count, a_cnt[c]);
            chk($sformatf("A_busy_c%0d", c), busy, a_busy[c]);
            chk($sformatf("A_done_c%0d", c), done, a_done[c]);
            chk($sformatf("A_inc_c%0d", c), inc, a_inc[c]);
            chk($sformatf("A_clr_c%0d", c), clr, a_clr[c]);
            cyc();
        end
        start = 1'b0;
        // second sequence latched limit=7: RUN cycles 7..14, DONE 15; now at cycle 8
        for (int c = 8; c <= 16; c++) begin
            chk($sformatf("A2_done_c%0d", c), done, (c == 15) ? 1 : 0);
            if (c <= 14) chk($sformatf("A2_cnt_c%0d", c), count, c - 7);
            cyc();
        end

        // B: two passes, limit=2
        limit = 8'd2; passes = 4'd1;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            if (c == 3) passes = 4'd9;
            chk($sformatf("B_cnt_c%0d", c), count, b_cnt[c]);
            chk($sformatf("B_pidx_c%0d", c), pass_idx, b_pidx[c]);
            chk($sformatf("B_clr_c%0d", c), clr, b_clr[c]);
            chk($sformatf("B_done_c%0d", c), done, b_done[c]);
            chk($sformatf("B_busy_c%0d", c), busy, b_busy[c]);
            cyc();
        end
        start = 1'b0;

        // C: limit=0, one RUN cycle then DONE in cycle 2
        limit = 8'd0; passes = 4'd0; start = 1'b1;
        cyc(); start = 1'b0;
        chk("C_done_c1", done, 0); chk("C_inc_c1", inc, 0); chk("C_busy_c1", busy, 1);
        cyc();
        chk("C_done_c2", done, 1); chk("C_cnt_c2", count, 0);
        cyc();
        chk("C_done_c3", done, 0); chk("C_busy_c3", busy, 0);
        cyc();

        // D: limit=255, no overflow, done in cycle 257
        limit = 8'd255; start = 1'b1;
        cyc(); start = 1'b0;
        for (int c = 1; c <= 258; c++) begin
            if (c == 1 || c == 128 || c >= 255) begin
                chk($sformatf("D_done_c%0d", c), done, (c == 257) ? 1 : 0);
                if (c <= 257) chk($sformatf("D_cnt_c%0d", c), count, (c == 257) ? 255 : c - 1);
            end
            cyc();
        end

        // E: abort in cycle 3 of limit=5
        limit = 8'd5; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        chk("E_cnt_c3", count, 2);
        abort = 1'b1;
        cyc(); abort = 1'b0;
        chk("E_cnt_c4", count, 0); chk("E_busy_c4", busy, 0); chk("E_clr_c4", clr, 1);
        for (int c = 5; c <= 10; c++) begin
            chk($sformatf("E_done_c%0d", c), done, 0);
            cyc();
        end

        // F: abort coincident with tc on last pass
        limit = 8'd1; start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        chk("F_cnt_c2", count, 1); chk("F_inc_tc", inc, 0);
        abort = 1'b1;
        cyc(); abort = 1'b0;
        chk("F_done_c3", done, 0); chk("F_busy_c3", busy, 0);
        cyc();
        chk("F_done_c4", done, 0);

        // G: max passes (15), limit=0: RUN at odd cycles, done in cycle 32
        limit = 8'd0; passes = 4'd15; start = 1'b1;
        cyc(); start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 2 || c == 31) chk($sformatf("G_pidx_c%0d", c), pass_idx, (c == 2) ? 0 : 15);
            if (c == 2) chk("G_clr_wrap", clr, 1);
            if (c >= 30) chk($sformatf("G_done_c%0d", c), done, (c == 32) ? 1 : 0);
            if (c == 32) chk("G_pidx_done", pass_idx, 15);
            cyc();
        end

        // H: abort during WRAP
        passes = 4'd1; start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        chk("H_clr_wrap", clr, 1); chk("H_busy_wrap", busy, 1);
        abort = 1'b1;
        cyc(); abort = 1'b0;
        chk("H_busy_c3", busy, 0); chk("H_pidx_c3", pass_idx, 0); chk("H_done_c3", done, 0);
        cyc();

        // I: synchronous reset mid-sequence
        limit = 8'd5; passes = 4'd2; start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc(); rst = 1'b0;
        chk("I_busy", busy, 0); chk("I_cnt", count, 0); chk("I_clr", clr, 1); chk("I_done", done, 0);
        cyc();
        chk("I_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
